// File: rtl/beaker8_io_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | beaker8_io_pkg : Beaker8 I/O port map, VRAM slot op codes, VRAM width.     |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
package beaker8_io_pkg;

  localparam int VRAM_ADDR_W = 14;

  localparam logic [7:0] PORT_VRAM_WR  = 8'h00;
  localparam logic [7:0] PORT_VRAM_RD  = 8'h01;
  localparam logic [7:0] PORT_VDP_REG0 = 8'h40;
  localparam logic [7:0] PORT_VDP_REG1 = 8'h41;
  localparam logic [7:0] PORT_VDP_REG2 = 8'h42;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_VID  = 2'd1,
    OP_WR   = 2'd2,
    OP_PF   = 2'd3
  } op_t;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_VID = 0;
  localparam int GNT_WR  = 1;
  localparam int GNT_PF  = 2;

  function automatic logic [2:0] op_to_grant(input op_t op);
    logic [2:0] g;
    g = 3'b000;
    case (op)
      OP_VID:  g[GNT_VID] = 1'b1;
      OP_WR:   g[GNT_WR]  = 1'b1;
      OP_PF:   g[GNT_PF]  = 1'b1;
      default: g = 3'b000;
    endcase
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vram_slot_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | vram_slot_arbiter : fixed-priority VRAM slot select with starvation guard. |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module vram_slot_arbiter
  import beaker8_io_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_vid_req,
  input  logic       i_wbuf_full,
  input  logic       i_pf_pending,
  output logic [2:0] o_grant,
  output op_t        o_op
);

  localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_pf_req;
  logic             w_cpu_req;
  logic             w_starved;
  op_t              w_op;

  // A prefetch behind a buffered write would read stale RAM, so it waits.
  assign w_pf_req  = i_pf_pending & ~i_wbuf_full;
  assign w_cpu_req = i_wbuf_full | w_pf_req;
  assign w_starved = w_cpu_req & (r_starve_cnt >= CNT_MAX);

  always_comb begin
    w_op = OP_NONE;
    if (reset) begin
      w_op = OP_NONE;
    end else if (i_vid_req && !w_starved) begin
      w_op = OP_VID;
    end else if (i_wbuf_full) begin
      w_op = OP_WR;
    end else if (w_pf_req) begin
      w_op = OP_PF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !w_cpu_req) begin
      r_starve_cnt <= '0;
    end else if (w_op == OP_VID) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end else begin
      r_starve_cnt <= '0;
    end
  end

  assign o_op    = w_op;
  assign o_grant = op_to_grant(w_op);

endmodule
`default_nettype wire

// File: rtl/vram_port_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | vram_port_arbiter : shares Beaker8 VRAM between CPU I/O ports and the VDP. |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module vram_port_arbiter
  import beaker8_io_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_io_wr,
  input  logic              i_io_rd,
  input  logic [7:0]        i_io_port,
  input  logic [7:0]        i_io_wdata,
  output logic [7:0]        o_io_rdata,
  output logic              o_io_wait,
  input  logic              i_vid_req,
  input  logic [ADDR_W-1:0] i_vid_addr,
  output logic              o_vid_ack,
  output logic [7:0]        o_vid_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [7:0]        o_mem_wdata,
  input  logic [7:0]        i_mem_rdata,
  output logic [7:0]        o_mode_reg
);

  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_wbuf_addr;
  logic [ADDR_W-1:0] r_last_addr;
  logic [7:0]        r_wbuf_data;
  logic [7:0]        r_rbuf;
  logic [7:0]        r_mode;
  logic              r_wbuf_full;
  logic              r_rbuf_valid;
  logic              r_pf_pending;
  logic              r_pf_stale;
  logic              r_vid_ack;
  op_t               r_inflight;

  logic [2:0]        w_grant;
  op_t               w_op;
  logic              w_wait_wr;
  logic              w_wait_rd;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_wr_data;
  logic              w_wr_mode;
  logic              w_wr_lo;
  logic              w_wr_hi;
  logic              w_ptr_evt;
  logic              w_pf_good_inflight;
  logic              w_pf_req;
  logic              w_pf_done;
  logic [ADDR_W-1:0] w_mem_addr;

  assign w_wait_wr = i_io_wr & (i_io_port == PORT_VRAM_WR) & r_wbuf_full;
  assign w_wait_rd = i_io_rd & (i_io_port == PORT_VRAM_RD) & ~r_rbuf_valid & ~i_io_wr;
  assign o_io_wait = w_wait_wr | w_wait_rd;

  assign w_wr_acc  = i_io_wr & ~w_wait_wr;
  assign w_rd_acc  = i_io_rd & ~i_io_wr & (i_io_port == PORT_VRAM_RD) & r_rbuf_valid;
  assign w_wr_data = w_wr_acc & (i_io_port == PORT_VRAM_WR);
  assign w_wr_mode = w_wr_acc & (i_io_port == PORT_VDP_REG0);
  assign w_wr_lo   = w_wr_acc & (i_io_port == PORT_VDP_REG1);
  assign w_wr_hi   = w_wr_acc & (i_io_port == PORT_VDP_REG2);
  // Anything that moves ptr makes rbuf and any in-flight prefetch stale.
  assign w_ptr_evt = w_wr_data | w_wr_lo | w_wr_hi | w_rd_acc;

  // Only a still-useful prefetch in flight blocks issuing another one.
  assign w_pf_good_inflight = (r_inflight == OP_PF) & ~r_pf_stale;
  assign w_pf_req  = r_pf_pending & ~w_pf_good_inflight;
  assign w_pf_done = w_pf_good_inflight & ~w_ptr_evt;

  vram_slot_arbiter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_slot_arb (
    .clk          (clk),
    .reset        (reset),
    .i_vid_req    (i_vid_req),
    .i_wbuf_full  (r_wbuf_full),
    .i_pf_pending (w_pf_req),
    .o_grant      (w_grant),
    .o_op         (w_op)
  );

  always_comb begin
    w_mem_addr = r_last_addr;
    case (w_op)
      OP_VID:  w_mem_addr = i_vid_addr;
      OP_WR:   w_mem_addr = r_wbuf_addr;
      OP_PF:   w_mem_addr = r_ptr;
      default: w_mem_addr = r_last_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr        <= '0;
      r_mode       <= '0;
      r_wbuf_full  <= 1'b0;
      r_wbuf_addr  <= '0;
      r_wbuf_data  <= '0;
      r_rbuf       <= '0;
      r_rbuf_valid <= 1'b0;
      r_pf_pending <= 1'b0;
      r_pf_stale   <= 1'b0;
      r_inflight   <= OP_NONE;
      r_vid_ack    <= 1'b0;
      r_last_addr  <= '0;
    end else begin
      r_inflight  <= w_op;
      r_vid_ack   <= w_grant[GNT_VID];
      r_pf_stale  <= w_grant[GNT_PF] & w_ptr_evt;
      r_last_addr <= w_mem_addr;

      if (w_wr_mode) begin
        r_mode <= i_io_wdata;
      end

      if (w_wr_lo) begin
        r_ptr[7:0] <= i_io_wdata;
      end else if (w_wr_hi) begin
        r_ptr[ADDR_W-1:8] <= i_io_wdata[ADDR_W-9:0];
      end else if (w_wr_data || w_rd_acc) begin
        r_ptr <= r_ptr + ADDR_W'(1);
      end

      if (w_wr_data) begin
        r_wbuf_full <= 1'b1;
        r_wbuf_addr <= r_ptr;
        r_wbuf_data <= i_io_wdata;
      end else if (w_grant[GNT_WR]) begin
        r_wbuf_full <= 1'b0;
      end

      if (w_ptr_evt) begin
        r_rbuf_valid <= 1'b0;
        r_pf_pending <= 1'b1;
      end else if (w_pf_done) begin
        r_rbuf       <= i_mem_rdata;
        r_rbuf_valid <= 1'b1;
        r_pf_pending <= 1'b0;
      end
    end
  end

  assign o_io_rdata  = (i_io_port == PORT_VRAM_RD) ? r_rbuf : 8'h00;
  assign o_vid_ack   = r_vid_ack;
  assign o_vid_data  = i_mem_rdata;
  assign o_mem_addr  = w_mem_addr;
  assign o_mem_we    = w_grant[GNT_WR];
  assign o_mem_wdata = r_wbuf_data;
  assign o_mode_reg  = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_vram_port_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_vram_port_arbiter : directed bench for vram_port_arbiter with RAM model.|
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_vram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_wr, io_rd;
  logic [7:0]  io_port, io_wdata;
  logic [7:0]  o_io_rdata;
  logic        o_io_wait;
  logic        vid_req;
  logic [13:0] vid_addr;
  logic        o_vid_ack;
  logic [7:0]  o_vid_data;
  logic [13:0] o_mem_addr;
  logic        o_mem_we;
  logic [7:0]  o_mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  o_mode_reg;

  logic [7:0]  ram [0:16383];
  logic        do_init;
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  vram_port_arbiter #(.ADDR_W(14), .STARVE_MAX(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_io_wr     (io_wr),
    .i_io_rd     (io_rd),
    .i_io_port   (io_port),
    .i_io_wdata  (io_wdata),
    .o_io_rdata  (o_io_rdata),
    .o_io_wait   (o_io_wait),
    .i_vid_req   (vid_req),
    .i_vid_addr  (vid_addr),
    .o_vid_ack   (o_vid_ack),
    .o_vid_data  (o_vid_data),
    .o_mem_addr  (o_mem_addr),
    .o_mem_we    (o_mem_we),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (mem_rdata),
    .o_mode_reg  (o_mode_reg)
  );

  function automatic logic [7:0] init_byte(input int a);
    logic [31:0] t;
    if (a == 'h1234) return 8'h5A;
    if (a == 'h1235) return 8'hA5;
    t = a * 7 + 3;
    return t[7:0];
  endfunction

  // Synchronous single-port RAM: data appears the cycle after the address.
  always @(posedge clk) begin
    if (do_init) begin
      for (int a = 0; a < 16384; a++) ram[a] <= init_byte(a);
    end else begin
      if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
      mem_rdata <= ram[o_mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] data, output int waits);
    waits = 0;
    @(negedge clk);
    io_wr = 1'b1; io_port = port; io_wdata = data;
    #1;
    while (o_io_wait && waits < 20) begin
      @(negedge clk); #1; waits++;
    end
    @(posedge clk); #1;
    io_wr = 1'b0;
  endtask

  task automatic io_read(output logic [7:0] d, output int waits);
    waits = 0;
    @(negedge clk);
    io_rd = 1'b1; io_port = 8'h01;
    #1;
    while (o_io_wait && waits < 20) begin
      @(negedge clk); #1; waits++;
    end
    d = o_io_rdata;
    @(posedge clk); #1;
    io_rd = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         w;
    logic [7:0] d;
    reset = 1'b1; io_wr = 1'b0; io_rd = 1'b0; io_port = 8'h00; io_wdata = 8'h00;
    vid_req = 1'b0; vid_addr = '0; do_init = 1'b1;
    @(posedge clk); #1 do_init = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_vid_ack", o_vid_ack, 0);
    chk("rst_mem_we", o_mem_we, 0);
    chk("rst_mode", o_mode_reg, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_io_wait", o_io_wait, 0);
    reset = 1'b0;

    // rbuf starts invalid, so a data-port read must stall.
    @(negedge clk); io_rd = 1'b1; io_port = 8'h01; #1;
    chk("rd_after_rst_waits", o_io_wait, 1);
    io_rd = 1'b0;

    // Pointer load, two buffered writes.
    io_write(8'h41, 8'h00, w);
    io_write(8'h42, 8'h20, w);
    io_write(8'h00, 8'hAA, w);
    chk("wr1_wait", w, 0);
    io_write(8'h00, 8'hBB, w);
    chk("wr2_wait", w, 1);
    io_write(8'h40, 8'h5C, w);
    chk("mode_reg", o_mode_reg, 8'h5C);
    repeat (6) @(negedge clk);
    chk("ram_2000", ram['h2000], 8'hAA);
    chk("ram_2001", ram['h2001], 8'hBB);
    io_read(d, w);
    chk("ptr_2002_read", d, init_byte('h2002));
    repeat (4) @(negedge clk);
    io_port = 8'h40; #1;
    chk("rdata_other_port", o_io_rdata, 0);

    // Read-ahead through the data port.
    io_write(8'h41, 8'h34, w);
    io_write(8'h42, 8'h12, w);
    io_read(d, w);
    chk("rd1_data", d, 8'h5A);
    chk("rd1_wait_le2", (w <= 2), 1);
    io_read(d, w);
    chk("rd2_data", d, 8'hA5);
    chk("rd2_wait_le2", (w <= 2), 1);

    // Pointer wrap at the top of VRAM.
    io_write(8'h41, 8'hFF, w);
    io_write(8'h42, 8'h3F, w);
    io_write(8'h00, 8'h11, w);
    io_write(8'h00, 8'h22, w);
    chk("wrap_wr2_wait", w, 1);
    repeat (6) @(negedge clk);
    chk("ram_3fff", ram['h3FFF], 8'h11);
    chk("ram_0000", ram['h0000], 8'h22);
    io_read(d, w);
    chk("wrap_read_0001", d, init_byte(1));
    repeat (6) @(negedge clk);

    // Continuous video with a pending write: ptr is now $0002.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vid_req = 1'b1; vid_addr = 14'h100 + 14'(i);
      io_wr = (i == 0); io_port = 8'h00; io_wdata = 8'h77;
      #1;
      if (i == 0) chk("starve_wr_accept", o_io_wait, 0);
      chk($sformatf("starve_ack_%0d", i), o_vid_ack, (i >= 1 && i != 10));
      if (i >= 1 && i != 10)
        chk($sformatf("starve_data_%0d", i), o_vid_data, init_byte('h100 + i - 1));
      chk($sformatf("starve_we_%0d", i), o_mem_we, (i == 9));
      if (i == 9) chk("starve_wr_addr", o_mem_addr, 14'h0002);
    end
    @(negedge clk); vid_req = 1'b0; io_wr = 1'b0;
    repeat (6) @(negedge clk);
    chk("ram_0002", ram['h0002], 8'h77);

    // Pointer high byte rewritten while the low-byte prefetch is in flight.
    io_write(8'h41, 8'h40, w);
    io_write(8'h42, 8'h15, w);
    io_read(d, w);
    chk("stale_pf_read", d, init_byte('h1540));
    chk("stale_pf_wait_le2", (w <= 2), 1);
    repeat (6) @(negedge clk);

    // Reset during a video grant with a write still buffered (ptr $1541).
    @(negedge clk);
    vid_req = 1'b1; vid_addr = 14'h200; io_wr = 1'b1; io_port = 8'h00; io_wdata = 8'h99;
    #1;
    chk("rst_wr_accept", o_io_wait, 0);
    @(negedge clk);
    io_wr = 1'b0; vid_addr = 14'h201; #1;
    chk("pre_rst_vid_ack", o_vid_ack, 1);
    chk("pre_rst_we", o_mem_we, 0);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_vid_ack", o_vid_ack, 0);
    chk("mid_rst_we", o_mem_we, 0);
    chk("mid_rst_mode", o_mode_reg, 0);
    chk("mid_rst_mem_addr", o_mem_addr, 0);
    chk("mid_rst_io_wait", o_io_wait, 0);
    reset = 1'b0; vid_req = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_vid_ack", o_vid_ack, 0);
    chk("lost_write_1541", ram['h1541], init_byte('h1541));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
